// File: rtl/pc_unit.sv
// pc_unit: program-counter register stage with BOOT/RUN/HALT sequencing,
// priority next-PC selection (trap > stall > jump > branch > PC+4) and a retired-instruction counter.
module pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCsum,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        trap,
    input  logic        stall,
    output logic [31:0] PCout,
    output logic        fetch_valid,
    output logic        misalign_err,
    output logic [31:0] instr_count
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;
    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, count_q, count_d, target;
    logic        valid_q, err_q, run, mis, advance;
    // Every qualifier is gated by run first so X inputs outside RUN collapse to 0.
    always_comb begin
        run     = state_q == RUN;
        target  = jump ? jump_target : branch_target;
        mis     = run && !trap && !stall && (jump || branch_taken) && target[1:0] != 2'b00;
        advance = run && (trap || !stall) && !mis;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            count_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            valid_q <= state_d == RUN;
            err_q   <= state_d == HALT;
        end
    end
    always_comb begin
        state_d = state_q == BOOT ? RUN : mis ? HALT : state_q;
    end
    always_comb begin
        pc_d    = !advance ? pc_q :
                  trap ? TRAP_VECTOR :
                  jump ? jump_target :
                  branch_taken ? branch_target : PCsum;
        count_d = advance ? count_q + 32'd1 : count_q;
    end
    assign PCout        = pc_q;
    assign fetch_valid  = valid_q;
    assign misalign_err = err_q;
    assign instr_count  = count_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed-vector bench for pc_unit with an ideal PC+4 adder attached.
module tb_pc_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCsum;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        trap;
    logic        stall;
    logic [31:0] PCout;
    logic        fetch_valid;
    logic        misalign_err;
    logic [31:0] instr_count;
    int          tests = 0;
    int          fails = 0;

    pc_unit dut (
        .clk(clk), .reset(reset), .PCsum(PCsum),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .trap(trap), .stall(stall),
        .PCout(PCout), .fetch_valid(fetch_valid), .misalign_err(misalign_err),
        .instr_count(instr_count)
    );

    assign PCsum = PCout + 32'd4;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_state(input string tag, input logic [31:0] pc, input logic v,
                                input logic e, input logic [31:0] cnt);
        chk({tag, ".pc"}, PCout, pc);
        chk({tag, ".valid"}, {31'd0, fetch_valid}, {31'd0, v});
        chk({tag, ".err"}, {31'd0, misalign_err}, {31'd0, e});
        chk({tag, ".cnt"}, instr_count, cnt);
    endtask

    task automatic idle;
        branch_taken = 0; branch_target = 0; jump = 0; jump_target = 0; trap = 0; stall = 0;
    endtask

    initial begin
        reset = 1; idle();
        tick(); tick();
        expect_state("reset", 32'h0, 0, 0, 0);
        // Boot edge: trap must be ignored
        reset = 0; trap = 1;
        tick(); expect_state("boot", 32'h0, 1, 0, 0);
        trap = 0;
        tick(); expect_state("seq4", 32'h4, 1, 0, 1);
        tick(); expect_state("seq8", 32'h8, 1, 0, 2);
        tick(); expect_state("seq12", 32'hC, 1, 0, 3);
        tick(); expect_state("seq16", 32'h10, 1, 0, 4);
        jump = 1; jump_target = 32'h40; branch_taken = 1; branch_target = 32'h80;
        tick(); expect_state("jump_wins", 32'h40, 1, 0, 5);
        idle();
        tick(); expect_state("after_jump", 32'h44, 1, 0, 6);
        jump = 1; jump_target = 32'h50; branch_taken = 1; branch_target = 32'h83;
        tick(); expect_state("jump_masks_bad_branch", 32'h50, 1, 0, 7);
        idle(); jump = 1; jump_target = 32'h20;
        tick(); expect_state("goto20", 32'h20, 1, 0, 8);
        idle(); stall = 1;
        tick(); expect_state("stall1", 32'h20, 1, 0, 8);
        jump = 1; jump_target = 32'h300;
        tick(); expect_state("stall2_drop_jump", 32'h20, 1, 0, 8);
        jump = 0;
        tick(); expect_state("stall3", 32'h20, 1, 0, 8);
        stall = 0;
        tick(); expect_state("unstall", 32'h24, 1, 0, 9);
        trap = 1; stall = 1;
        tick(); expect_state("trap_over_stall", 32'h80, 1, 0, 10);
        idle(); jump = 1; jump_target = 32'hFFFF_FFFC;
        tick(); expect_state("goto_top", 32'hFFFF_FFFC, 1, 0, 11);
        idle();
        tick(); expect_state("pc_wrap", 32'h0, 1, 0, 12);
        force dut.count_q = 32'hFFFF_FFFE;
        #1;
        release dut.count_q;
        tick(); expect_state("cnt_max", 32'h4, 1, 0, 32'hFFFF_FFFF);
        tick(); expect_state("cnt_wrap", 32'h8, 1, 0, 0);
        branch_taken = 1; branch_target = 32'h102;
        tick(); expect_state("misalign_branch", 32'h8, 0, 1, 0);
        idle(); jump = 1; jump_target = 32'h40; trap = 1;
        tick(); expect_state("halt_frozen", 32'h8, 0, 1, 0);
        jump = 1'bx; trap = 1'bx; stall = 1'bx; branch_taken = 1'bx; jump_target = 'x; branch_target = 'x;
        tick(); expect_state("halt_x_inputs", 32'h8, 0, 1, 0);
        reset = 1;
        tick(); expect_state("reset_in_halt", 32'h0, 0, 0, 0);
        reset = 0;
        tick(); expect_state("reboot_halt", 32'h0, 1, 0, 0);
        idle();
        tick(); expect_state("run_after_reboot", 32'h4, 1, 0, 1);
        stall = 1;
        tick(); expect_state("stall_before_reset", 32'h4, 1, 0, 1);
        reset = 1;
        tick(); expect_state("reset_in_stall", 32'h0, 0, 0, 0);
        reset = 0;
        tick(); expect_state("reboot_stall", 32'h0, 1, 0, 0);
        stall = 0;
        tick(); expect_state("run_again", 32'h4, 1, 0, 1);
        jump = 1; jump_target = 32'h41;
        tick(); expect_state("misalign_jump", 32'h4, 0, 1, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
